// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer. Holds the PC, fetches one instruction at a time
// over the instruction-memory handshake, presents it to decode while in EXEC,
// and on retire advances the PC by 4 or by a signed word offset when the
// flow-control decision is taken. Also keeps saturating counts of retired
// and offset-taken instructions.
//
// Ports
//   CLK            in   clock, all state updates on the rising edge
//   RESET_N        in   asynchronous active-low reset
//   OFFSET_TAKEN   in   flow-control decision for the instruction in EXEC
//   OFFSET         in   signed word offset for the instruction in EXEC
//   STALL          in   data-memory busywait, holds EXEC while high
//   IMEM_BUSYWAIT  in   instruction memory busy, IMEM_RDATA valid when low
//   IMEM_RDATA     in   instruction word from memory
//   IMEM_READ      out  fetch request (high throughout FETCH)
//   IMEM_ADDR      out  word address of the fetch, PC[IMEM_AW+1:2]
//   PC             out  current program counter
//   INSTRUCTION    out  latched instruction for decode
//   INSTR_VALID    out  high while INSTRUCTION is live (EXEC)
//   INSTR_COUNT    out  retired instructions, saturating
//   TAKEN_COUNT    out  retired instructions with OFFSET_TAKEN=1, saturating
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               OFFSET_TAKEN,
    input  logic [7:0]         OFFSET,
    input  logic               STALL,
    input  logic               IMEM_BUSYWAIT,
    input  logic [31:0]        IMEM_RDATA,
    output logic               IMEM_READ,
    output logic [IMEM_AW-1:0] IMEM_ADDR,
    output logic [31:0]        PC,
    output logic [31:0]        INSTRUCTION,
    output logic               INSTR_VALID,
    output logic [CNT_W-1:0]   INSTR_COUNT,
    output logic [CNT_W-1:0]   TAKEN_COUNT
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        fetch_done;
    logic        retire;
    logic [31:0] pc_seq;
    logic [31:0] pc_offset;
    logic [31:0] pc_target;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs. IMEM_READ/INSTR_VALID decode the state
    // register directly so an asynchronous reset drops them at once.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        IMEM_READ   = 1'b0;
        INSTR_VALID = 1'b0;
        fetch_done  = 1'b0;
        retire      = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                IMEM_READ = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    fetch_done = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                INSTR_VALID = 1'b1;
                if (!STALL) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC arithmetic, modulo 2^32. The offset is in words, so it is sign
    // extended and shifted left by two before being added to PC+4.
    // ------------------------------------------------------------------
    always_comb begin
        pc_seq    = PC + 32'd4;
        pc_offset = {{22{OFFSET[7]}}, OFFSET, 2'b00};
        pc_target = OFFSET_TAKEN ? (pc_seq + pc_offset) : pc_seq;
    end

    assign IMEM_ADDR = PC[IMEM_AW+1:2];

    // ------------------------------------------------------------------
    // PC and instruction latch
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PC          <= RESET_PC;
            INSTRUCTION <= '0;
        end else begin
            if (fetch_done) begin
                INSTRUCTION <= IMEM_RDATA;
            end
            if (retire) begin
                PC <= pc_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating retire / taken counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            INSTR_COUNT <= '0;
            TAKEN_COUNT <= '0;
        end else if (retire) begin
            if (INSTR_COUNT != '1) begin
                INSTR_COUNT <= INSTR_COUNT + CNT_W'(1);
            end
            if (OFFSET_TAKEN && (TAKEN_COUNT != '1)) begin
                TAKEN_COUNT <= TAKEN_COUNT + CNT_W'(1);
            end
        end
    end

endmodule
